box_downscale: RTL



---
 rtl/downscale_pkg.sv | 17 +
 rtl/downscale_out_reg.sv | 43 ++++
 rtl/box_downscale.sv | 130 +++++++++++++
 3 files changed

// File: rtl/downscale_pkg.sv
// Shared types and sizing for the 4:1 box downscaler.
package downscale_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    PAD   = 1'b1
  } ds_state_t;

  localparam int unsigned GROUP = 4;
  localparam int unsigned CNT_W = 2;

  // Sum of GROUP samples needs two extra bits to hold 4*(2^bd-1).
  function automatic int unsigned sum_w(input int unsigned bit_depth);
    return bit_depth + 2;
  endfunction

endpackage

// File: rtl/downscale_out_reg.sv
// Output holding register with valid/ready handshake; exposes o_out_free.
module downscale_out_reg
  import downscale_pkg::*;
#(
  parameter int unsigned bit_depth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [bit_depth-1:0] i_load_pix,
  input  logic                 i_load_last,
  input  logic                 i_out_ready,
  output logic [bit_depth-1:0] o_pix,
  output logic                 o_valid,
  output logic                 o_last,
  output logic                 o_out_free
);

  logic [bit_depth-1:0] r_pix;
  logic                 r_valid;
  logic                 r_last;

  assign o_pix      = r_pix;
  assign o_valid    = r_valid;
  assign o_last     = r_last;
  assign o_out_free = ~r_valid | i_out_ready;

  // A load wins over a drain, so load+transfer in one cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_pix   <= i_load_pix;
      r_valid <= 1'b1;
      r_last  <= i_load_last;
    end else if (r_valid & i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/box_downscale.sv
// 4:1 horizontal box downscaler with edge-clamp padding of partial trailing groups.
// Optional macro DOWNSCALE_ROUND_EN selects round-half-up averaging (default truncates).
module box_downscale
  import downscale_pkg::*;
#(
  parameter int unsigned bit_depth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bit_depth-1:0] pix_in,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [bit_depth-1:0] pix_out,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned      SUM_W    = sum_w(bit_depth);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GROUP - 1);

  ds_state_t            r_state;
  ds_state_t            w_state_nxt;
  logic [SUM_W-1:0]     r_sum;
  logic [SUM_W-1:0]     w_sum_nxt;
  logic [SUM_W-1:0]     w_sum_final;
  logic [SUM_W-1:0]     w_rounded;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [bit_depth-1:0] r_pad_pix;
  logic [bit_depth-1:0] w_pad_nxt;
  logic [bit_depth-1:0] w_addend;
  logic [bit_depth-1:0] w_result;
  logic                 w_cnt_full;
  logic                 w_out_free;
  logic                 w_in_xfer;
  logic                 w_load;
  logic                 w_load_last;

  assign w_cnt_full = (r_cnt == CNT_FULL);
  assign in_ready   = ~reset & (r_state == ACCUM) & (~w_cnt_full | w_out_free);
  assign w_in_xfer  = in_valid & in_ready;

  // PAD replays the row's last pixel in place of fresh input.
  assign w_addend    = (r_state == PAD) ? r_pad_pix : pix_in;
  assign w_sum_final = r_sum + SUM_W'(w_addend);

`ifdef DOWNSCALE_ROUND_EN
  assign w_rounded = w_sum_final + SUM_W'(2);
`else
  assign w_rounded = w_sum_final;
`endif

  assign w_result = w_rounded[SUM_W-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_pad_pix <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sum     <= w_sum_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pad_pix <= w_pad_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_pad_nxt   = r_pad_pix;
    w_load      = 1'b0;
    w_load_last = 1'b0;

    unique case (r_state)
      ACCUM: begin
        if (w_in_xfer) begin
          if (w_cnt_full) begin
            w_load      = 1'b1;
            w_load_last = in_last;
            w_sum_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_sum_nxt = w_sum_final;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (in_last) begin
              w_pad_nxt   = pix_in;
              w_state_nxt = PAD;
            end
          end
        end
      end
      PAD: begin
        if (!w_cnt_full) begin
          w_sum_nxt = w_sum_final;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_out_free) begin
          w_load      = 1'b1;
          w_load_last = 1'b1;
          w_sum_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  downscale_out_reg #(
    .bit_depth(bit_depth)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_pix (w_result),
    .i_load_last(w_load_last),
    .i_out_ready(out_ready),
    .o_pix      (pix_out),
    .o_valid    (out_valid),
    .o_last     (out_last),
    .o_out_free (w_out_free)
  );

endmodule
